axis_ram_reader: RTL and testbench
==================================

AXIS_RAM_READER -- requirements
Module: axis_ram_reader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 20: width of the beat-address counter, giving a circular buffer of 2^ADDR_WIDTH beats.
REQ-002 SHALL have parameter AXI_ID_WIDTH, default 6: AXI ID width.
REQ-003 SHALL have parameters AXI_ADDR_WIDTH, default 32, and AXI_DATA_WIDTH, default 64: AXI address and data widths.
REQ-004 SHALL have parameter AXIS_TDATA_WIDTH, default 64, constrained to be <= AXI_DATA_WIDTH: stream data width.
REQ-005 SHALL have parameter FIFO_DEPTH, default 64, a power of two >= 32: depth of the read-data buffer in beats.
REQ-006 aclk  in  1  sole clock; all logic on the rising edge.
REQ-007 areset  in  1  asynchronous, active-high reset.
REQ-008 cfg_data  in  AXI_ADDR_WIDTH  byte base address of the circular buffer, aligned to a 16-beat burst.
REQ-009 sts_data  out  ADDR_WIDTH  beat address of the next burst to be requested.
REQ-010 m_axi_arid/araddr/arlen[3:0]/arsize[2:0]/arburst[1:0]/arcache[3:0]/arvalid  out; m_axi_arready  in: AXI3 read-address channel.
REQ-011 m_axi_rid  in  AXI_ID_WIDTH; m_axi_rdata  in  AXI_DATA_WIDTH; m_axi_rlast, m_axi_rvalid  in  1; m_axi_rready  out  1: AXI3 read-data channel.
REQ-012 m_axis_tdata  out  AXIS_TDATA_WIDTH; m_axis_tvalid  out  1; m_axis_tready  in  1: AXI-Stream master.

Function
REQ-013 Constant outputs SHALL be: arlen=15, arsize=log2(AXI_DATA_WIDTH/8), arburst=INCR (01), arcache=1111.
REQ-014 araddr SHALL equal cfg_data + (addr_reg << arsize); arid SHALL equal id_reg; sts_data SHALL equal addr_reg.
REQ-015 The FSM SHALL have three states. IDLE: no request outstanding. ADDR: arvalid=1. DATA: the burst is accepted and beats are being received.
REQ-016 IDLE->ADDR SHALL occur when credit >= 16, where credit = FIFO_DEPTH - (FIFO occupancy + beats reserved but not yet received).
REQ-017 On entry to ADDR, 16 beats of credit SHALL be reserved; there SHALL be no other path into ADDR.
REQ-018 ADDR->DATA SHALL occur on arvalid & arready. In the same cycle, addr_reg SHALL increase by 16, wrapping modulo 2^ADDR_WIDTH, and id_reg SHALL increase by 1, wrapping.
REQ-019 arvalid and araddr SHALL stay stable while ADDR is waiting for arready.
REQ-020 m_axi_rready SHALL be 1 in all states except reset; the reservation scheme guarantees the FIFO never overflows.
REQ-021 Each rvalid beat SHALL be written into the FIFO as rdata[AXIS_TDATA_WIDTH-1:0]; rid and rresp SHALL be ignored.
REQ-022 DATA->IDLE SHALL occur on rvalid & rlast. The FSM SHALL return to ADDR in the next cycle if credit >= 16.
REQ-023 Exactly one burst SHALL be outstanding at a time.
REQ-024 m_axis_tvalid SHALL equal FIFO not-empty, and m_axis_tdata SHALL be the FIFO head in first-word-fall-through mode.
REQ-025 A FIFO pop SHALL occur on tvalid & tready.
REQ-026 A simultaneous FIFO push and pop SHALL leave occupancy unchanged.
REQ-027 Minimum latency from an rvalid beat to m_axis_tvalid SHALL be 1 cycle.
REQ-028 A simultaneous reservation (IDLE->ADDR) and pop SHALL update credit by -16+1 in that cycle.
REQ-029 Stream data SHALL leave in strictly ascending beat-address order, wrapping from beat 2^ADDR_WIDTH-1 to beat 0.
REQ-030 A change of cfg_data while a burst is outstanding SHALL affect only later bursts.

Reset
REQ-031 While areset=1: FSM=IDLE, addr_reg=0, id_reg=0, credit=FIFO_DEPTH, FIFO empty, arvalid=0, rready=0, m_axis_tvalid=0, sts_data=0.
REQ-032 areset SHALL take effect asynchronously; deassertion SHALL be synchronised to aclk before it is used by the FSM.
REQ-033 A reset during ADDR or DATA SHALL abandon the burst and discard buffered data. Read data still in flight SHALL NOT be accepted after reset; draining it is the system's responsibility.

Verification
REQ-034 Reset release, cfg_data=0x1000_0000, arready=1, tready=1 -> first AR at araddr 0x1000_0000, arid 0, arlen 15; second AR at 0x1000_0080, arid 1; stream output equals memory words 0..31 in order.
REQ-035 tready=0 throughout, FIFO_DEPTH=64 -> exactly 4 bursts issued, then arvalid stays 0. After one tready pulse, still no AR (credit 1). After 16 pops, one new AR.
REQ-036 arready held 0 for 10 cycles -> arvalid stays 1 with araddr constant; sts_data advances only on the handshake cycle.
REQ-037 ADDR_WIDTH=6, continuous drain -> after beat 63 the next AR address returns to cfg_data; sts_data wraps 48->0.
REQ-038 rvalid beats sent with random gaps, and tready toggled at random -> no beat lost or duplicated, output order matches memory, tvalid never set while the FIFO is empty.
REQ-039 areset asserted on beat 7 of a burst -> all outputs take reset values in the same cycle; after release, the first AR is at cfg_data with arid 0.

Source files
------------

// File: rtl/axis_ram_reader.sv
// Streams a circular buffer out of AXI3 memory as 16-beat bursts, buffering read
// data in a first-word-fall-through FIFO whose space is reserved before each request.
module axis_ram_reader #(
    parameter int unsigned ADDR_WIDTH       = 20,
    parameter int unsigned AXI_ID_WIDTH     = 6,
    parameter int unsigned AXI_ADDR_WIDTH   = 32,
    parameter int unsigned AXI_DATA_WIDTH   = 64,
    parameter int unsigned AXIS_TDATA_WIDTH = 64,
    parameter int unsigned FIFO_DEPTH       = 64
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [AXI_ADDR_WIDTH-1:0]   cfg_data,
    output logic [ADDR_WIDTH-1:0]       sts_data,
    output logic [AXI_ID_WIDTH-1:0]     m_axi_arid,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [3:0]                  m_axi_arlen,
    output logic [2:0]                  m_axi_arsize,
    output logic [1:0]                  m_axi_arburst,
    output logic [3:0]                  m_axi_arcache,
    output logic                        m_axi_arvalid,
    input  logic                        m_axi_arready,
    input  logic [AXI_ID_WIDTH-1:0]     m_axi_rid,
    input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic                        m_axi_rlast,
    input  logic                        m_axi_rvalid,
    output logic                        m_axi_rready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready
);

    localparam int unsigned SIZE = $clog2(AXI_DATA_WIDTH / 8);
    localparam int unsigned PW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CW   = PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    logic [1:0]                  rst_sync_r;
    logic                        rst_s;
    state_t                      state_r;
    logic [ADDR_WIDTH-1:0]       addr_r;
    logic [AXI_ID_WIDTH-1:0]     id_r;
    logic [AXI_ID_WIDTH-1:0]     arid_r;
    logic [AXI_ADDR_WIDTH-1:0]   araddr_r;
    logic                        arvalid_r;
    logic                        rready_r;
    logic [CW-1:0]               resv_r;
    logic [CW-1:0]               count_r;
    logic [PW-1:0]               wr_ptr_r;
    logic [PW-1:0]               rd_ptr_r;
    logic [AXIS_TDATA_WIDTH-1:0] mem_r [FIFO_DEPTH];

    logic [CW-1:0]               credit_s;
    logic                        reserve_s;
    logic                        push_s;
    logic                        pop_s;
    logic                        tvalid_s;
    logic                        unused_s;

    // Reset asserts immediately but releases only after two clean clock edges
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rst_sync_r <= 2'b11;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b0};
        end
    end

    assign rst_s = rst_sync_r[1];

    // Credit counts FIFO slots neither occupied nor promised to an outstanding burst
    always_comb begin
        credit_s  = CW'(FIFO_DEPTH) - count_r - resv_r;
        reserve_s = 1'b0;
        if (state_r == ST_IDLE) begin
            reserve_s = (credit_s >= CW'(16));
        end else begin
            reserve_s = 1'b0;
        end
    end

    assign tvalid_s = (count_r != CW'(0));
    assign push_s   = m_axi_rvalid & rready_r & (state_r == ST_DATA);
    assign pop_s    = tvalid_s & m_axis_tready;

    // Burst request FSM; araddr/arid are captured on entry to ADDR so they hold while waiting
    always_ff @(posedge aclk or posedge rst_s) begin
        if (rst_s) begin
            state_r   <= ST_IDLE;
            addr_r    <= '0;
            id_r      <= '0;
            arid_r    <= '0;
            araddr_r  <= '0;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b0;
        end else begin
            rready_r <= 1'b1;
            case (state_r)
                ST_IDLE: begin
                    if (reserve_s) begin
                        state_r   <= ST_ADDR;
                        arvalid_r <= 1'b1;
                        araddr_r  <= cfg_data + (AXI_ADDR_WIDTH'(addr_r) << SIZE);
                        arid_r    <= id_r;
                    end
                end
                ST_ADDR: begin
                    if (m_axi_arready) begin
                        state_r   <= ST_DATA;
                        arvalid_r <= 1'b0;
                        addr_r    <= addr_r + ADDR_WIDTH'(16);
                        id_r      <= id_r + AXI_ID_WIDTH'(1);
                    end
                end
                ST_DATA: begin
                    if (push_s && m_axi_rlast) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    arvalid_r <= 1'b0;
                end
            endcase
        end
    end

    // Reserved-but-not-received beats: +16 per request, -1 per arriving beat
    always_ff @(posedge aclk or posedge rst_s) begin
        if (rst_s) begin
            resv_r <= '0;
        end else if (reserve_s) begin
            resv_r <= resv_r + CW'(16);
        end else if (push_s) begin
            resv_r <= resv_r - CW'(1);
        end
    end

    // FIFO storage; no reset needed since occupancy gates every read
    always_ff @(posedge aclk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= m_axi_rdata[AXIS_TDATA_WIDTH-1:0];
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge aclk or posedge rst_s) begin
        if (rst_s) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign sts_data      = addr_r;
    assign m_axi_arid    = arid_r;
    assign m_axi_araddr  = araddr_r;
    assign m_axi_arlen   = 4'd15;
    assign m_axi_arsize  = 3'(SIZE);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arcache = 4'b1111;
    assign m_axi_arvalid = arvalid_r;
    assign m_axi_rready  = rready_r;
    assign m_axis_tvalid = tvalid_s;
    assign m_axis_tdata  = mem_r[rd_ptr_r];

    assign unused_s = ^{m_axi_rid, m_axi_rdata};

endmodule

// File: tb/tb_axis_ram_reader.sv
// Bench for axis_ram_reader: scenario table with randomized handshakes plus directed
// sequences for credit exhaustion, AR back-pressure, and reset mid-burst.
module tb_axis_ram_reader;

    localparam int AW    = 6;
    localparam int IDW   = 6;
    localparam int AAW   = 32;
    localparam int ADW   = 64;
    localparam int TDW   = 64;
    localparam int DEPTH = 64;

    logic            aclk = 1'b0;
    logic            areset = 1'b1;
    logic [AAW-1:0]  cfg_data = '0;
    logic [AW-1:0]   sts_data;
    logic [IDW-1:0]  m_axi_arid;
    logic [AAW-1:0]  m_axi_araddr;
    logic [3:0]      m_axi_arlen;
    logic [2:0]      m_axi_arsize;
    logic [1:0]      m_axi_arburst;
    logic [3:0]      m_axi_arcache;
    logic            m_axi_arvalid;
    logic            m_axi_arready = 1'b0;
    logic [IDW-1:0]  m_axi_rid = '0;
    logic [ADW-1:0]  m_axi_rdata = '0;
    logic            m_axi_rlast = 1'b0;
    logic            m_axi_rvalid = 1'b0;
    logic            m_axi_rready;
    logic [TDW-1:0]  m_axis_tdata;
    logic            m_axis_tvalid;
    logic            m_axis_tready = 1'b0;

    always #5 aclk = ~aclk;

    axis_ram_reader #(
        .ADDR_WIDTH(AW), .AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(AAW),
        .AXI_DATA_WIDTH(ADW), .AXIS_TDATA_WIDTH(TDW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .aclk(aclk), .areset(areset), .cfg_data(cfg_data), .sts_data(sts_data),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arcache(m_axi_arcache),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
    );

    typedef struct {
        logic [31:0] cfg;
        int          tready_pct;
        int          arready_pct;
        int          rgap_pct;
        int          beats;
        logic [31:0] exp_first_araddr;
        int          exp_first_arid;
    } vec_t;

    vec_t vecs[4];

    int          n_cmp = 0;
    int          n_err = 0;
    int          ar_cnt, out_cnt, occ_m, beat_idx;
    bit          burst_act;
    logic [31:0] burst_base, stream_cfg, first_araddr, saved_araddr;
    int          first_arid, saved_sts;
    bit          prev_arvalid, prev_hs;
    logic [31:0] prev_araddr;
    int          tready_pct, arready_pct, rgap_pct;
    bit          found;

    // Memory contents: each 64-bit word is derived from its own byte address
    function automatic logic [63:0] memf(input logic [31:0] a);
        return {a ^ 32'h5A5A_5A5A, a};
    endfunction

    // n-th burst after reset starts at beat 16*n of the 64-beat ring
    function automatic logic [31:0] exp_araddr(input int n);
        return stream_cfg + 32'(((n * 16) % 64) * 8);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(negedge aclk);
        m_axis_tready = ($urandom_range(99) < tready_pct);
        m_axi_arready = ($urandom_range(99) < arready_pct);
        if (burst_act && !areset) begin
            if (!(m_axi_rvalid && !m_axi_rready)) m_axi_rvalid = ($urandom_range(99) >= rgap_pct);
            m_axi_rdata = memf(burst_base + 32'(beat_idx * 8));
            m_axi_rlast = (beat_idx == 15);
            m_axi_rid   = IDW'($urandom);
        end else begin
            m_axi_rvalid = 1'b0;
            m_axi_rlast  = 1'b0;
        end
        chk("tvalid_vs_occupancy", m_axis_tvalid, occ_m != 0);
        chk("sts_data", sts_data, (ar_cnt * 16) % 64);
        if (prev_arvalid && !prev_hs) begin
            chk("ar_hold_valid", m_axi_arvalid, 1);
            chk("ar_hold_addr", m_axi_araddr, prev_araddr);
        end
        if (m_axi_arvalid) chk("one_outstanding", burst_act, 0);
        if (m_axi_arvalid && m_axi_arready) begin
            chk("araddr", m_axi_araddr, exp_araddr(ar_cnt));
            chk("arid", m_axi_arid, ar_cnt % 64);
            chk("ar_const", {m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arcache},
                {4'd15, 3'd3, 2'b01, 4'hF});
            if (ar_cnt == 0) begin
                first_araddr = m_axi_araddr;
                first_arid   = int'(m_axi_arid);
            end
            burst_act  = 1'b1;
            burst_base = m_axi_araddr;
            beat_idx   = 0;
            ar_cnt++;
        end
        if (m_axi_rvalid && m_axi_rready) begin
            occ_m++;
            if (m_axi_rlast) burst_act = 1'b0;
            beat_idx++;
        end
        if (m_axis_tvalid && m_axis_tready) begin
            chk("tdata", m_axis_tdata, memf(stream_cfg + 32'((out_cnt % 64) * 8)));
            out_cnt++;
            occ_m--;
        end
        prev_arvalid = m_axi_arvalid;
        prev_hs      = m_axi_arvalid && m_axi_arready;
        prev_araddr  = m_axi_araddr;
    endtask

    task automatic do_reset(input int n);
        @(negedge aclk);
        areset        = 1'b1;
        m_axi_rvalid  = 1'b0;
        m_axi_rlast   = 1'b0;
        m_axi_arready = 1'b0;
        m_axis_tready = 1'b0;
        #1;
        chk("reset_outputs", {m_axi_arvalid, m_axi_rready, m_axis_tvalid, sts_data}, '0);
        ar_cnt = 0; out_cnt = 0; occ_m = 0; beat_idx = 0; burst_act = 1'b0;
        prev_arvalid = 1'b0; prev_hs = 1'b0; first_araddr = '1; first_arid = -1;
        repeat (n) @(negedge aclk);
        areset = 1'b0;
    endtask

    task automatic wait_out(input int n, input int budget);
        for (int i = 0; i < budget && out_cnt < n; i++) cycle();
        chk("beats_out", out_cnt, n);
    endtask

    initial begin
        vecs[0] = '{cfg: 32'h1000_0000, tready_pct: 100, arready_pct: 100, rgap_pct: 0,
                    beats: 80, exp_first_araddr: 32'h1000_0000, exp_first_arid: 0};
        vecs[1] = '{cfg: 32'h2000_0200, tready_pct: 50, arready_pct: 70, rgap_pct: 30,
                    beats: 100, exp_first_araddr: 32'h2000_0200, exp_first_arid: 0};
        vecs[2] = '{cfg: 32'h0000_0000, tready_pct: 30, arready_pct: 100, rgap_pct: 60,
                    beats: 80, exp_first_araddr: 32'h0000_0000, exp_first_arid: 0};
        vecs[3] = '{cfg: 32'hFFFF_FE00, tready_pct: 90, arready_pct: 40, rgap_pct: 10,
                    beats: 140, exp_first_araddr: 32'hFFFF_FE00, exp_first_arid: 0};

        for (int v = 0; v < 4; v++) begin
            stream_cfg  = vecs[v].cfg;
            cfg_data    = vecs[v].cfg;
            tready_pct  = vecs[v].tready_pct;
            arready_pct = vecs[v].arready_pct;
            rgap_pct    = vecs[v].rgap_pct;
            do_reset(3);
            wait_out(vecs[v].beats, 4000);
            chk("first_araddr", first_araddr, vecs[v].exp_first_araddr);
            chk("first_arid", first_arid, vecs[v].exp_first_arid);
        end

        // Credit exhaustion with a stalled stream
        stream_cfg = 32'h3000_0000; cfg_data = stream_cfg;
        tready_pct = 0; arready_pct = 100; rgap_pct = 0;
        do_reset(3);
        repeat (200) cycle();
        chk("bursts_when_full", ar_cnt, 4);
        chk("arvalid_when_full", m_axi_arvalid, 0);
        tready_pct = 100; cycle(); tready_pct = 0;
        repeat (40) cycle();
        chk("bursts_after_1_pop", ar_cnt, 4);
        tready_pct = 100; repeat (14) cycle(); tready_pct = 0;
        repeat (40) cycle();
        chk("bursts_after_15_pops", ar_cnt, 4);
        tready_pct = 100; cycle(); tready_pct = 0;
        repeat (40) cycle();
        chk("bursts_after_16_pops", ar_cnt, 5);

        // AR back-pressure, with cfg_data disturbed while the request waits
        tready_pct = 100; arready_pct = 0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            cycle();
            found = m_axi_arvalid;
        end
        chk("arvalid_seen", found, 1);
        saved_araddr = m_axi_araddr;
        saved_sts    = int'(sts_data);
        cfg_data     = 32'hDEAD_0000;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("stall_arvalid", m_axi_arvalid, 1);
            chk("stall_araddr", m_axi_araddr, saved_araddr);
            chk("stall_sts", sts_data, saved_sts);
        end
        cfg_data = stream_cfg;
        arready_pct = 100;
        cycle();
        cycle();
        chk("sts_after_handshake", sts_data, (saved_sts + 16) % 64);
        wait_out(out_cnt + 40, 2000);

        // Reset in the middle of a burst
        stream_cfg = 32'h4000_0400; cfg_data = stream_cfg;
        tready_pct = 0; arready_pct = 100; rgap_pct = 20;
        do_reset(3);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            cycle();
            found = burst_act && (beat_idx == 7);
        end
        chk("reached_beat7", found, 1);
        chk("tvalid_before_reset", m_axis_tvalid, 1);
        do_reset(3);
        tready_pct = 100;
        wait_out(20, 1000);
        chk("first_araddr_after_reset", first_araddr, 32'h4000_0400);
        chk("first_arid_after_reset", first_arid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
